// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes AA - BB one bit per clock, LSB first,
// with a registered borrow chain and start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] AA,
    input  logic [WIDTH-1:0] BB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DD,
    output logic             BO,
    output logic             ZF
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [WIDTH-1:0] rp_reg;
    logic             bor_reg;
    logic [CW-1:0]    cnt_reg;

    logic             d_bit;
    logic             bor_next;
    logic [WIDTH-1:0] rp_next;

    // One full-subtractor cell; the difference bit enters rp from the top so
    // that after WIDTH shifts bit 0 of the result sits in rp[0].
    always_comb begin
        d_bit    = ra_reg[0] ^ rb_reg[0] ^ bor_reg;
        bor_next = (~ra_reg[0] & rb_reg[0]) | (~(ra_reg[0] ^ rb_reg[0]) & bor_reg);
        rp_next  = {d_bit, rp_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            rp_reg    <= '0;
            bor_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            DD        <= '0;
            BO        <= 1'b0;
            ZF        <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra_reg    <= AA;
                        rb_reg    <= BB;
                        rp_reg    <= '0;
                        bor_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    ra_reg  <= ra_reg >> 1;
                    rb_reg  <= rb_reg >> 1;
                    rp_reg  <= rp_next;
                    bor_reg <= bor_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    // Results are loaded from the next-state values so the last
                    // processed bit is included on the same edge.
                    if (cnt_reg == LAST_BIT) begin
                        DD        <= rp_next;
                        BO        <= bor_next;
                        ZF        <= (rp_next == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8: directed
// cases plus randomized back-to-back operations against an arithmetic model.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] aa4 = '0, bb4 = '0;
    logic       busy4, done4, bo4, zf4;
    logic [3:0] dd4;

    logic       start8 = 1'b0;
    logic [7:0] aa8 = '0, bb8 = '0;
    logic       busy8, done8, bo8, zf8;
    logic [7:0] dd8;

    int n_vec = 0;
    int n_err = 0;

    // Last result each DUT should be holding: index 0 = WIDTH 4, 1 = WIDTH 8.
    logic [31:0] prev_dd [2];
    logic        prev_bo [2];
    logic        prev_zf [2];

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .AA(aa4), .BB(bb4),
        .busy(busy4), .done(done4), .DD(dd4), .BO(bo4), .ZF(zf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .AA(aa8), .BB(bb8),
        .busy(busy8), .done(done8), .DD(dd8), .BO(bo8), .ZF(zf8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int w, output logic b, output logic dn,
                          output logic [31:0] d, output logic bo, output logic zf);
        if (w == 4) begin
            b = busy4; dn = done4; d = {28'd0, dd4}; bo = bo4; zf = zf4;
        end else begin
            b = busy8; dn = done8; d = {24'd0, dd8}; bo = bo8; zf = zf8;
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (w == 4) begin
            start4 = s; aa4 = a[3:0]; bb4 = b[3:0];
        end else begin
            start8 = s; aa8 = a[7:0]; bb8 = b[7:0];
        end
    endtask

    task automatic check_outputs(input string tag, input int w, input logic eb, input logic edn,
                                 input logic [31:0] ed, input logic ebo, input logic ezf);
        logic b, dn, bo, zf;
        logic [31:0] d;
        sample(w, b, dn, d, bo, zf);
        check({tag, ".busy"}, {31'd0, b}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, dn}, {31'd0, edn});
        check({tag, ".DD"}, d, ed);
        check({tag, ".BO"}, {31'd0, bo}, {31'd0, ebo});
        check({tag, ".ZF"}, {31'd0, zf}, {31'd0, ezf});
    endtask

    // One full operation at maximum rate: returns right after E(W+1), so the
    // next call's accepting edge is E(W+2).
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input string tag);
        int k;
        logic [31:0] mask, ed;
        logic ebo, ezf;
        k = (w == 4) ? 0 : 1;
        mask = (32'd1 << w) - 1;
        ed  = (a - b) & mask;
        ebo = (a < b);
        ezf = (a == b);
        drive(w, 1'b1, a, b);
        tick();                                   // E0
        drive(w, 1'b0, $urandom & mask, $urandom & mask);
        check_outputs({tag, "@E0"}, w, 1'b1, 1'b0, prev_dd[k], prev_bo[k], prev_zf[k]);
        repeat (w - 1) tick();                    // E(W-1)
        check_outputs({tag, "@Ew-1"}, w, 1'b1, 1'b0, prev_dd[k], prev_bo[k], prev_zf[k]);
        tick();                                   // E(W)
        check_outputs({tag, "@Ew"}, w, 1'b0, 1'b1, ed, ebo, ezf);
        tick();                                   // E(W+1)
        check_outputs({tag, "@Ew+1"}, w, 1'b0, 1'b0, ed, ebo, ezf);
        prev_dd[k] = ed; prev_bo[k] = ebo; prev_zf[k] = ezf;
    endtask

    task automatic clear_prev();
        for (int i = 0; i < 2; i++) begin
            prev_dd[i] = '0; prev_bo[i] = 1'b0; prev_zf[i] = 1'b1;
        end
    endtask

    initial begin
        clear_prev();
        // Reset then idle
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_outputs("reset4", 4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_outputs("reset8", 8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        repeat (3) tick();
        check_outputs("idle4", 4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Basic, then hold check
        run_op(4, 32'd9, 32'd3, "basic");
        repeat (10) tick();
        check_outputs("hold", 4, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);

        // Borrow and zero
        run_op(4, 32'd3, 32'd9, "borrow");
        run_op(4, 32'd15, 32'd15, "zero");
        run_op(4, 32'd0, 32'd1, "wrap");

        // Reset mid-operation
        drive(4, 1'b1, 32'd12, 32'd5);
        tick();                                   // E0
        drive(4, 1'b0, 32'd0, 32'd0);
        repeat (2) tick();                        // E2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs("midrst", 4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        repeat (6) tick();
        check_outputs("midrst_quiet", 4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        clear_prev();
        run_op(4, 32'd12, 32'd5, "after_rst");

        // Start held while busy: second op accepted only at E6
        drive(4, 1'b1, 32'd9, 32'd3);
        tick();                                   // E0
        drive(4, 1'b1, 32'd1, 32'd1);
        repeat (4) tick();                        // E4
        check_outputs("sb_first", 4, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0);
        tick();                                   // E5
        check_outputs("sb_idle", 4, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);
        tick();                                   // E6
        check_outputs("sb_accept", 4, 1'b1, 1'b0, 32'd6, 1'b0, 1'b0);
        repeat (4) tick();                        // E10
        check_outputs("sb_second", 4, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
        drive(4, 1'b0, 32'd0, 32'd0);
        tick();                                   // E11
        check_outputs("sb_end", 4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        prev_dd[0] = 32'd0; prev_bo[0] = 1'b0; prev_zf[0] = 1'b1;

        // Randomized back-to-back, both widths
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 15);
            b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 15);
            run_op(4, a, b, "rnd4");
        end
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 255);
            run_op(8, a, b, "rnd8");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
